stump_control: RTL
==================

# stump_control

Control sequencer for the 16-bit Stump datapath. It holds the instruction register and the condition-code (CC) register, and runs a three-state FETCH/EXECUTE/MEMORY machine with a memory-ready handshake. It decodes the current instruction into ALU function, operand-select, register-file, memory and flag-update strobes. It sits beside the ALU and register file and is the only block that drives their enables.

## Interface
- No parameters. Widths are fixed by the Stump ISA: 16-bit data, 3-bit register fields, 4 flags ordered {N,Z,V,C}.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  16  memory read data; the instruction word in FETCH, load data in MEMORY.
- mem_ready  in  1  memory handshake; the current access completes on a cycle where it is high.
- flags_in  in  4  ALU flags {N,Z,V,C}, valid in EXECUTE.
- state  out  2  FETCH=00, EXECUTE=01, MEMORY=10; 11 is never produced.
- ir  out  16  instruction register.
- alu_func  out  3  ALU function select.
- c_in  out  1  carry into the ALU; always equal to cc[0].
- imm_sel  out  2  B-operand select: 0=register, 1=sign-extended ir[4:0], 2=sign-extended ir[7:0].
- dest, src_a, src_b  out  3 each  register-file addresses.
- reg_we  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0=ALU, 1=mem_rdata.
- pc_inc  out  1  increment R7 (PC).
- addr_sel  out  1  memory address source: 0=PC, 1=address register.
- addr_en  out  1  load the address register from the ALU result.
- mem_ren, mem_wen  out  1 each  memory read / write strobes.
- cc  out  4  condition-code register.

## Operation
- Instruction fields:
  - op = ir[15:13]; opcodes 000–101 are ADD, ADC, SUB, SBC, AND, OR.
  - op 110 is LD/ST; ir[11] selects 0=LD, 1=ST.
  - op 111 is Bcc; ir[11:8] is the condition, ir[7:0] the offset.
  - ir[12]=1 selects an immediate operand; ir[11]=S (set flags) for ALU ops.
  - ir[10:8]=dest, ir[7:5]=srcA, ir[4:2]=srcB.
- FETCH:
  - Drives mem_ren=1 and addr_sel=0.
  - Holds in FETCH while mem_ready=0.
  - When mem_ready=1: ir<=mem_rdata, pc_inc=1, next state EXECUTE.
- EXECUTE, ALU ops (000–101):
  - alu_func=op; imm_sel=ir[12]?1:0; reg_we=1; wb_sel=0.
  - cc_en=ir[11], so cc<=flags_in at the end of EXECUTE when S=1.
  - Next state FETCH.
- EXECUTE, LD/ST:
  - alu_func=000; imm_sel=ir[12]?1:0; addr_en=1; reg_we=0.
  - CC is never updated. Next state MEMORY.
- EXECUTE, Bcc:
  - alu_func=000, src_a=7, dest=7, imm_sel=2.
  - reg_we=1 only if the condition is true; CC unchanged.
  - Next state FETCH.
- Conditions 0–15: AL, NV, HI(~C&~Z), LS(C|Z), CC(~C), CS(C), NE(~Z), EQ(Z), VC(~V), VS(V), PL(~N), MI(N), GE(N==V), LT(N!=V), GT(~Z&N==V), LE(Z|N!=V).
- MEMORY: addr_sel=1; holds while mem_ready=0.
  - LD: mem_ren=1; on mem_ready=1 assert reg_we=1 with wb_sel=1 and dest=ir[10:8].
  - ST: mem_wen=1; src_a=ir[10:8] supplies the store data.
  - Next state FETCH after the completing cycle.
- All strobes are 0 outside the cases listed above.
- c_in follows cc[0] in every state.
- src_a/src_b/dest are driven from ir whenever not overridden; they are don't-care in FETCH.

## Timing
- state, ir and cc are registered. All other outputs decode combinationally from state, ir, cc and mem_ready.
- Reset values: state=FETCH, ir=0, cc=0000.
  - During reset, all strobes are 0 except the FETCH defaults, which appear in the first post-reset cycle.
- Reset asserted in any state, including mid-MEMORY wait, returns to FETCH on the next edge with no write strobe issued in that cycle.
- Cycle counts with zero wait states:
  - ALU op or branch: 2 cycles.
  - LD/ST: 3 cycles.
  - Each mem_ready=0 cycle adds exactly one cycle to FETCH or MEMORY.
- mem_ready is ignored in EXECUTE.
- Flags written in EXECUTE are visible on cc and c_in in the following FETCH. An immediately following ADC therefore uses them.

## Test plan
- Reset, then fetch ADD R1,R2,R3 (0x014C) with mem_ready=1 -> the next cycle shows state=01, alu_func=000, reg_we=1, with cc unchanged at 0000.
- ADDS with flags_in=0101 -> after EXECUTE, cc=0101 and c_in=1. A following ADC decodes alu_func=001.
- BEQ with cc Z=1 -> reg_we=1, dest=7, imm_sel=2. The same instruction with Z=0 -> reg_we=0. Sweep all 16 conditions against all 16 cc values.
- LD with mem_ready low for 3 MEMORY cycles -> mem_ren held; reg_we and wb_sel=1 only in the completing cycle. Total 6 cycles.
- ST -> mem_wen=1 in MEMORY only and src_a=ir[10:8]. ST with S-bit pattern present -> cc never changes.
- Assert rst during a MEMORY wait -> state=00, cc=0000, ir=0, and mem_wen/reg_we both 0 in the reset cycle.

Source files
------------

// File: rtl/stump_control.sv
// Stump control sequencer: instruction/CC registers, FETCH/EXECUTE/MEMORY
// machine with memory-ready handshake, and combinational strobe decode.
module stump_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [3:0]  flags_in,
  output logic [1:0]  state,
  output logic [15:0] ir,
  output logic [2:0]  alu_func,
  output logic        c_in,
  output logic [1:0]  imm_sel,
  output logic [2:0]  dest,
  output logic [2:0]  src_a,
  output logic [2:0]  src_b,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_inc,
  output logic        addr_sel,
  output logic        addr_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  cc
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    MEMORY  = 2'b10
  } state_t;

  state_t     cur;
  logic [2:0] op;
  logic       is_ldst;
  logic       is_bcc;
  logic       is_st;
  logic       cc_en;
  logic       cond_ok;
  logic       f_n, f_z, f_v, f_c;

  assign op      = ir[15:13];
  assign is_ldst = (op == 3'b110);
  assign is_bcc  = (op == 3'b111);
  assign is_st   = ir[11];
  assign {f_n, f_z, f_v, f_c} = cc;
  assign state   = cur;
  assign c_in    = cc[0];

  always_comb begin
    cond_ok = 1'b0;
    case (ir[11:8])
      4'd0:  cond_ok = 1'b1;
      4'd1:  cond_ok = 1'b0;
      4'd2:  cond_ok = ~f_c & ~f_z;
      4'd3:  cond_ok = f_c | f_z;
      4'd4:  cond_ok = ~f_c;
      4'd5:  cond_ok = f_c;
      4'd6:  cond_ok = ~f_z;
      4'd7:  cond_ok = f_z;
      4'd8:  cond_ok = ~f_v;
      4'd9:  cond_ok = f_v;
      4'd10: cond_ok = ~f_n;
      4'd11: cond_ok = f_n;
      4'd12: cond_ok = (f_n == f_v);
      4'd13: cond_ok = (f_n != f_v);
      4'd14: cond_ok = ~f_z & (f_n == f_v);
      default: cond_ok = f_z | (f_n != f_v);
    endcase
  end

  // Every strobe is gated by rst so a reset landing mid-access issues no write.
  always_comb begin
    alu_func = '0;
    imm_sel  = '0;
    dest     = ir[10:8];
    src_a    = ir[7:5];
    src_b    = ir[4:2];
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    pc_inc   = 1'b0;
    addr_sel = 1'b0;
    addr_en  = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    cc_en    = 1'b0;
    if (!rst) begin
      case (cur)
        FETCH: begin
          mem_ren = 1'b1;
          pc_inc  = mem_ready;
        end
        EXECUTE: begin
          if (is_bcc) begin
            src_a   = 3'd7;
            dest    = 3'd7;
            imm_sel = 2'd2;
            reg_we  = cond_ok;
          end else if (is_ldst) begin
            imm_sel = ir[12] ? 2'd1 : 2'd0;
            addr_en = 1'b1;
          end else begin
            alu_func = op;
            imm_sel  = ir[12] ? 2'd1 : 2'd0;
            reg_we   = 1'b1;
            cc_en    = ir[11];
          end
        end
        MEMORY: begin
          addr_sel = 1'b1;
          if (is_st) begin
            mem_wen = 1'b1;
            src_a   = ir[10:8];
          end else begin
            mem_ren = 1'b1;
            reg_we  = mem_ready;
            wb_sel  = mem_ready;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      ir  <= '0;
      cc  <= '0;
    end else begin
      case (cur)
        FETCH: begin
          if (mem_ready) begin
            ir  <= mem_rdata;
            cur <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (cc_en) cc <= flags_in;
          cur <= is_ldst ? MEMORY : FETCH;
        end
        MEMORY: begin
          if (mem_ready) cur <= FETCH;
        end
        default: cur <= FETCH;
      endcase
    end
  end

endmodule
